// File: rtl/gate_sweep_checker.sv
// Self-test engine for an N-input, single-output combinational gate.
// Walks every input pattern, waits SETTLE extra cycles, checks against TRUTH.
module gate_sweep_checker #(
    parameter int                 N_IN   = 2,
    parameter logic [2**N_IN-1:0] TRUTH  = 4'b0111,
    parameter int                 SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic [N_IN-1:0] stim,
    input  logic            dut_y,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_count,
    output logic            fail_valid,
    output logic [N_IN-1:0] first_fail_idx,
    output logic [1:0]      state_dbg
);

    // Handshake: start is a level request sampled only in IDLE; each accepted
    // request yields exactly one done pulse unless reset aborts the sweep.

    localparam int CW = N_IN + 1;
    localparam int SW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE);
    localparam logic [N_IN-1:0] LAST_PAT    = {N_IN{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [SW-1:0] settle_cnt;
    logic          window_end;
    logic          last_pat;
    logic          mismatch;
    logic [CW-1:0] err_next;

    // stim doubles as the pattern index while in DRIVE.
    assign window_end = (settle_cnt == SETTLE_LAST);
    assign last_pat   = (stim == LAST_PAT);
    assign mismatch   = (dut_y != TRUTH[stim]);
    assign err_next   = err_count + CW'(mismatch);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                busy = 1'b1;
                if (window_end && last_pat) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim           <= '0;
            settle_cnt     <= '0;
            err_count      <= '0;
            fail_valid     <= 1'b0;
            first_fail_idx <= '0;
            pass           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        stim           <= '0;
                        settle_cnt     <= '0;
                        err_count      <= '0;
                        fail_valid     <= 1'b0;
                        first_fail_idx <= '0;
                        pass           <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (window_end) begin
                        settle_cnt <= '0;
                        err_count  <= err_next;
                        if (mismatch && !fail_valid) begin
                            first_fail_idx <= stim;
                            fail_valid     <= 1'b1;
                        end
                        if (last_pat) begin
                            // pass reflects the count including this last sample.
                            stim <= '0;
                            pass <= (err_next == '0);
                        end else begin
                            stim <= stim + 1'b1;
                        end
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Bench for gate_sweep_checker: default NAND2 instance driven through a result
// table plus corner sequences, and a NAND3 / SETTLE=0 instance.
module tb_gate_sweep_checker;

    localparam int NPAT = 4;
    localparam int WIN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic [1:0] stim;
    logic       dut_y;
    logic       busy, done, pass, fail_valid;
    logic [2:0] err_count;
    logic [1:0] first_fail_idx;
    logic [1:0] state_dbg;
    int         gate_mode;

    // Modelled gate: 0 NAND, 1 stuck-at-0, 2 stuck-at-1, 3 AND; stim = {a,b}.
    always_comb begin
        case (gate_mode)
            0:       dut_y = ~(stim[1] & stim[0]);
            1:       dut_y = 1'b0;
            2:       dut_y = 1'b1;
            default: dut_y = stim[1] & stim[0];
        endcase
    end

    gate_sweep_checker u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stim(stim), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .fail_valid(fail_valid), .first_fail_idx(first_fail_idx), .state_dbg(state_dbg)
    );

    logic       start3, dut_y3, busy3, done3, pass3, fv3, stuck3;
    logic [2:0] stim3, ffi3;
    logic [3:0] err3;
    logic [1:0] st3;
    assign dut_y3 = stuck3 ? 1'b1 : ~&stim3;

    gate_sweep_checker #(.N_IN(3), .TRUTH(8'b0111_1111), .SETTLE(0)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .stim(stim3), .dut_y(dut_y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .fail_valid(fv3), .first_fail_idx(ffi3), .state_dbg(st3)
    );

    typedef struct {
        int         mode;
        logic [2:0] err;
        logic [1:0] ffi;
        logic       fv;
        logic       ps;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    int         done_cnt = 0;
    logic [1:0] exp_q[$];
    logic [2:0] exp3_q[$];
    vec_t       res_q[$];
    vec_t       vecs[5];

    always @(negedge clk) begin
        if (rst_n && done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1 in IDLE; returns at posedge+1 in the IDLE cycle after DONE.
    task automatic run_sweep(input vec_t v, input bit inject);
        vec_t r;
        int   d0;
        gate_mode = v.mode;
        for (int p = 0; p < NPAT; p++)
            for (int s = 0; s < WIN; s++) exp_q.push_back(2'(p));
        res_q.push_back(v);
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        check("clear_err", err_count, 0);
        check("clear_fv", fail_valid, 0);
        check("clear_pass", pass, 0);
        for (int c = 1; c <= NPAT * WIN; c++) begin
            if (inject && c == 3) start = 1'b1;
            if (inject && c == 4) start = 1'b0;
            check("busy", busy, 1);
            check("done_early", done, 0);
            check("stim", stim, exp_q.pop_front());
            step();
        end
        if (inject) start = 1'b1;
        check("done", done, 1);
        check("busy_in_done", busy, 0);
        check("stim_in_done", stim, 0);
        r = res_q.pop_front();
        check("err_count", err_count, r.err);
        check("first_fail_idx", first_fail_idx, r.ffi);
        check("fail_valid", fail_valid, r.fv);
        check("pass", pass, r.ps);
        step();
        start = 1'b0;
        check("done_single", done, 0);
        check("busy_after", busy, 0);
        check("err_held", err_count, r.err);
        check("pass_held", pass, r.ps);
        check("done_count", done_cnt - d0, 1);
        if (inject) begin
            step();
            check("no_requeue", busy, 0);
        end
    endtask

    task automatic run_sweep3(input bit stuck, input logic [3:0] e_err, input logic [2:0] e_ffi);
        stuck3 = stuck;
        for (int p = 0; p < 8; p++) exp3_q.push_back(3'(p));
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            check("n3_busy", busy3, 1);
            check("n3_stim", stim3, exp3_q.pop_front());
            step();
        end
        check("n3_done", done3, 1);
        check("n3_err", err3, e_err);
        check("n3_pass", pass3, e_err == 0);
        check("n3_fv", fv3, e_err != 0);
        check("n3_ffi", ffi3, e_ffi);
        step();
        check("n3_done_single", done3, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int d0;
        vecs[0] = '{mode: 0, err: 3'd0, ffi: 2'd0, fv: 1'b0, ps: 1'b1};
        vecs[1] = '{mode: 1, err: 3'd3, ffi: 2'd0, fv: 1'b1, ps: 1'b0};
        vecs[2] = '{mode: 2, err: 3'd1, ffi: 2'd3, fv: 1'b1, ps: 1'b0};
        vecs[3] = '{mode: 3, err: 3'd4, ffi: 2'd0, fv: 1'b1, ps: 1'b0};
        vecs[4] = '{mode: 0, err: 3'd0, ffi: 2'd0, fv: 1'b0, ps: 1'b1};

        rst_n = 1'b0; start = 1'b0; start3 = 1'b0; stuck3 = 1'b0; gate_mode = 0;
        repeat (3) step();
        check("rst_stim", stim, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_err", err_count, 0);
        check("rst_fv", fail_valid, 0);
        check("rst_state", state_dbg, 0);
        check("rst_state3", st3, 0);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) run_sweep(vecs[i], 1'b0);

        // start pulses in DRIVE and in the DONE cycle are dropped
        run_sweep(vecs[0], 1'b1);

        // reset during a failing sweep, at cycle 4
        gate_mode = 1;
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        check("abort_pre_stim", stim, 1);
        check("abort_pre_err", err_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_stim", stim, 0);
        check("abort_busy", busy, 0);
        check("abort_err", err_count, 0);
        check("abort_fv", fail_valid, 0);
        check("abort_ffi", first_fail_idx, 0);
        check("abort_pass", pass, 0);
        repeat (12) step();
        check("abort_no_done", done_cnt - d0, 0);
        rst_n = 1'b1;
        step();
        run_sweep(vecs[0], 1'b0);

        run_sweep3(1'b0, 4'd0, 3'd0);
        run_sweep3(1'b1, 4'd1, 3'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gate_sweep_checker.md
# gate_sweep_checker

Synthesizable self-test engine for the combinational gate library. It drives every input pattern of an N-input, single-output gate under test, waits a programmable settle time, and samples the gate output. It compares each sample against a truth-table parameter and reports the error count, the first failing pattern and pass/fail. It is the on-chip receiving/checking counterpart to the per-gate stimulus benches and sits between a control source (switch, host register) and the instantiated gate.

## Interface
- N_IN, default 2: number of gate inputs; patterns 0 .. 2^N_IN-1.
- TRUTH, default 4'b0111: expected output per pattern, width 2^N_IN. Bit i is the expected y when stim == i. The default is NAND with stim = {a,b}.
- SETTLE, default 1: extra hold cycles per pattern before sampling, >= 0.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- stim  out  N_IN  inputs to the gate under test (registered).
- dut_y  in  1  gate under test output.
- busy  out  1  high in DRIVE.
- done  out  1  one-cycle pulse at sweep end.
- pass  out  1  err_count == 0 for the last completed sweep.
- err_count  out  N_IN+1  mismatches in the last/current sweep; range 0 .. 2^N_IN, so it never saturates.
- fail_valid  out  1  at least one mismatch seen this sweep.
- first_fail_idx  out  N_IN  pattern index of the first mismatch; valid while fail_valid is high.

## Operation
- States: IDLE, DRIVE, DONE.
- IDLE:
  - stim = 0, busy = 0.
  - start = 1 → DRIVE. On that edge: idx = 0, settle counter = 0, err_count = 0, fail_valid = 0, first_fail_idx = 0, pass = 0.
- DRIVE:
  - stim = idx.
  - Each pattern is held for exactly SETTLE+1 cycles.
  - On the edge that ends the hold window, dut_y is compared with TRUTH[idx]. On mismatch, err_count increments. If fail_valid was 0, first_fail_idx is set to idx and fail_valid is set to 1.
  - The same edge advances idx. If idx was 2^N_IN-1, the FSM moves to DONE instead.
- DONE:
  - Lasts one cycle, with done = 1 and pass = (err_count == 0), using the final count including the last pattern.
  - stim returns to 0.
  - Next state is IDLE.
- Results are held until the next accepted start:
  - err_count, fail_valid, first_fail_idx and pass hold after DONE.
  - A new start clears them on its accepting edge.
- start is ignored while in DRIVE or DONE. There is no queuing, and a start in the DONE cycle is dropped.
- Reset (async assert, at any time, including mid-sweep):
  - State = IDLE.
  - stim, busy, done, pass, err_count, fail_valid and first_fail_idx are all 0.
  - The aborted sweep produces no done pulse.
- dut_y is treated as asynchronous-combinational from stim. It is only sampled at window end and ignored at every other cycle.

## Timing
- Latency: start accepted on edge E0 → DRIVE from E0.
  - Pattern i occupies cycles i·(SETTLE+1) .. (i+1)·(SETTLE+1)-1 after E0.
  - done is high in the cycle starting at edge E0 + 2^N_IN·(SETTLE+1).
- Defaults (N_IN = 2, SETTLE = 1): 8 DRIVE cycles, done in cycle 9 after start; the next start is accepted from cycle 10.
- SETTLE = 0: one cycle per pattern; dut_y is sampled one edge after stim changes.
- Back-to-back: start held high continuously produces a new sweep every 2^N_IN·(SETTLE+1)+2 cycles (DRIVE + DONE + IDLE).

## Test plan
- NAND DUT, defaults, start pulse:
  - stim walks 0,0,1,1,2,2,3,3.
  - done pulses once at cycle 9.
  - err_count = 0, pass = 1, fail_valid = 0.
- DUT stuck-at-0:
  - err_count = 3, first_fail_idx = 0, fail_valid = 1, pass = 0.
- DUT stuck-at-1:
  - err_count = 1, first_fail_idx = 3, pass = 0.
- DUT = AND:
  - err_count = 4, first_fail_idx = 0.
  - Then start a second sweep with a correct NAND: counters clear on start; final err_count = 0, pass = 1.
- start pulses during DRIVE and in the DONE cycle:
  - Both are ignored.
  - Exactly one done pulse occurs; sweep length is unchanged.
- Reset mid-sweep:
  - Assert rst_n = 0 at cycle 4.
  - All outputs go to 0 immediately (async) and there is no done pulse.
  - After release, a start gives a full clean sweep.
- Parameter variant (N_IN = 3, TRUTH = 8'b0111_1111 NAND3, SETTLE = 0):
  - 8 DRIVE cycles, done at cycle 9, pass = 1.
